// File: rtl/stage_seq_pkg.sv
// stage_seq_pkg: stage, FSM state and error encodings shared by the EKF-SLAM sequencer and array
package stage_seq_pkg;
    typedef enum logic [2:0] {
        STG_IDLE = 3'b000,
        STG_PRD  = 3'b001,
        STG_NEW  = 3'b010,
        STG_UPD  = 3'b100
    } stage_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_NL_WAIT, S_NL_CALC, S_NL_RET, S_RUN} state_t;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TO   = 2'b01;
    localparam logic [1:0] ERR_FULL = 2'b10;
    // fixed priority PRD > UPD > NEW over a pending set, one-hot result
    function automatic logic [2:0] pick(input logic [2:0] p);
        return p[0] ? 3'b001 : p[2] ? 3'b100 : p[1] ? 3'b010 : 3'b000;
    endfunction
endpackage

// File: rtl/stage_seq_if.sv
// stage_seq_if: sequencer <-> systolic array signals
// stage_val/stage_rdy: stage command; nonlinear_m_val/s_rdy: array nonlinear request;
// nonlinear_s_val/m_rdy: nonlinear result return; rsa_done: end of stage;
// landmark_num/l_k: registered landmark count and index to the array
interface stage_seq_if #(parameter int ROW_LEN = 10);
    logic [2:0]         stage_val, stage_rdy;
    logic [2:0]         nonlinear_m_val, nonlinear_s_rdy;
    logic [2:0]         nonlinear_s_val, nonlinear_m_rdy;
    logic               rsa_done;
    logic [ROW_LEN-1:0] landmark_num, l_k;
    modport master (
        output stage_val, nonlinear_s_rdy, nonlinear_s_val, landmark_num, l_k,
        input  stage_rdy, nonlinear_m_val, nonlinear_m_rdy, rsa_done
    );
    modport slave (
        input  stage_val, nonlinear_s_rdy, nonlinear_s_val, landmark_num, l_k,
        output stage_rdy, nonlinear_m_val, nonlinear_m_rdy, rsa_done
    );
endinterface

// File: rtl/stage_seq_arb.sv
// stage_arb: sticky pending stage requests with fixed-priority selection
// req_val: request pulses; take: clear the selected bit; sel: one-hot selected stage
module stage_arb
    import stage_seq_pkg::*;
(
    input  logic       clk,
    input  logic       sys_rst,
    input  logic [2:0] req_val,
    input  logic       take,
    output logic [2:0] sel
);
    logic [2:0] pend;
    assign sel = pick(pend);
    // a request arriving while its bit is taken stays pending
    always_ff @(posedge clk) begin
        if (sys_rst) pend <= 3'b000;
        else pend <= (pend & ~(take ? sel : 3'b000)) | req_val;
    end
endmodule

// File: rtl/stage_seq.sv
// stage_seq: EKF-SLAM stage sequencer driving the systolic array and the nonlinear unit
// clk/sys_rst: clock, sync active-high reset; req_val/req_lk: host requests and index;
// arr: array handshakes; nl_start/nl_done: nonlinear unit; busy/done/err/cur_stage: status
module stage_seq
    import stage_seq_pkg::*;
#(
    parameter int ROW_LEN      = 10,
    parameter int MAX_LANDMARK = 500,
    parameter int TO_W         = 16
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic [2:0]         req_val,
    input  logic [ROW_LEN-1:0] req_lk,
    stage_seq_if.master        arr,
    output logic               nl_start,
    input  logic               nl_done,
    output logic               busy,
    output logic               done,
    output logic [1:0]         err,
    output logic [2:0]         cur_stage
);
    state_t             state, nxt;
    logic [TO_W-1:0]    cnt;
    logic [2:0]         sel, stage;
    logic [ROW_LEN-1:0] lm, lk, lk_new, lk_upd;
    logic               take, full, tmo;
    stage_arb u_arb (
        .clk(clk),
        .sys_rst(sys_rst),
        .req_val(req_val),
        .take(take),
        .sel(sel)
    );
    assign full                = lm == ROW_LEN'(MAX_LANDMARK);
    assign busy                = state != S_IDLE;
    assign cur_stage           = stage;
    assign arr.stage_val       = state == S_ISSUE   ? stage : 3'b000;
    assign arr.nonlinear_s_rdy = state == S_NL_WAIT ? stage : 3'b000;
    assign arr.nonlinear_s_val = state == S_NL_RET  ? stage : 3'b000;
    assign arr.landmark_num    = lm;
    assign arr.l_k             = lk;
    always_comb begin
        nxt  = state;
        take = 1'b0;
        case (state)
            S_IDLE: if (sel != 3'b000) begin
                take = 1'b1;
                nxt  = (sel == STG_NEW && full) ? S_IDLE : S_ISSUE;
            end
            S_ISSUE:   if ((arr.stage_val & arr.stage_rdy) != 3'b000) nxt = S_NL_WAIT;
            S_NL_WAIT: if ((arr.nonlinear_m_val & stage) != 3'b000) nxt = S_NL_CALC;
            S_NL_CALC: if (nl_done) nxt = S_NL_RET;
            S_NL_RET:  if ((arr.nonlinear_m_rdy & stage) != 3'b000) nxt = S_RUN;
            S_RUN:     if (arr.rsa_done) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        // counter would reach all-ones on this edge with no progress: abandon the stage
        tmo = busy && nxt == state && cnt == {{(TO_W-1){1'b1}}, 1'b0};
        if (tmo) nxt = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            stage    <= 3'b000;
            lm       <= '0;
            lk       <= '0;
            lk_new   <= '0;
            lk_upd   <= '0;
            nl_start <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
        end else begin
            state    <= nxt;
            cnt      <= (nxt != state || nxt == S_IDLE) ? '0 : cnt + 1'b1;
            stage    <= nxt == S_IDLE ? 3'b000 : state == S_IDLE ? sel : stage;
            if (req_val[1]) lk_new <= req_lk;
            if (req_val[2]) lk_upd <= req_lk;
            if (state == S_IDLE && nxt == S_ISSUE && sel != STG_PRD) lk <= sel == STG_NEW ? lk_new : lk_upd;
            nl_start <= state == S_NL_WAIT && nxt == S_NL_CALC;
            done     <= state == S_RUN && arr.rsa_done;
            if (state == S_RUN && arr.rsa_done && stage == STG_NEW && !full) lm <= lm + 1'b1;
            err      <= tmo ? ERR_TO : (take && nxt == S_IDLE) ? ERR_FULL : ERR_NONE;
        end
    end
endmodule

// File: tb/tb_stage_seq.sv
// tb_stage_seq: randomized scoreboard bench for stage_seq with a reactive array/nonlinear partner
module tb_stage_seq;
    import stage_seq_pkg::*;
    localparam int RL   = 10;
    localparam int MAXL = 500;
    localparam int TW   = 4;
    typedef struct {
        logic [1:0] err;
        logic [2:0] stg;
        int         lm;
        int         lk;
    } ev_t;
    logic          clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [2:0]    req_val = 3'b000;
    logic [RL-1:0] req_lk = '0;
    logic          nl_start, nl_done, busy, done;
    logic [1:0]    err;
    logic [2:0]    cur_stage;
    ev_t           q[$];
    int            errors = 0;
    int            checks = 0;
    int            m_lm = 0;
    int            d[5];
    int            ph = 0;
    logic          no_rdy = 1'b0;
    logic          wrong = 1'b0;
    stage_seq_if #(.ROW_LEN(RL)) arr();
    stage_seq #(.ROW_LEN(RL), .MAX_LANDMARK(MAXL), .TO_W(TW)) dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .req_val(req_val),
        .req_lk(req_lk),
        .arr(arr),
        .nl_start(nl_start),
        .nl_done(nl_done),
        .busy(busy),
        .done(done),
        .err(err),
        .cur_stage(cur_stage)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask
    // reference: stages of one request batch are served PRD, UPD, NEW; NEW is refused at capacity
    task automatic expect_batch(input logic [2:0] b, input int lk);
        if (b[0]) q.push_back('{ERR_NONE, 3'b001, m_lm, -1});
        if (b[2]) q.push_back('{ERR_NONE, 3'b100, m_lm, lk});
        if (b[1]) begin
            if (m_lm == MAXL) q.push_back('{ERR_FULL, 3'b000, m_lm, -1});
            else begin
                m_lm++;
                q.push_back('{ERR_NONE, 3'b010, m_lm, lk});
            end
        end
    endtask
    task automatic req(input logic [2:0] b, input int lk);
        @(posedge clk); #1;
        req_val = b;
        req_lk  = RL'(lk);
        @(posedge clk); #1;
        req_val = 3'b000;
    endtask
    task automatic drain(input int limit);
        int n = 0;
        while ((q.size() != 0 || busy) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL drain: %0d events outstanding after %0d cycles, required 0", q.size(), limit);
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic set_rand(input int hi);
        d[0] = $urandom_range(0, hi);
        d[1] = $urandom_range(0, hi);
        d[2] = $urandom_range(1, hi + 1);
        d[3] = $urandom_range(0, hi);
        d[4] = $urandom_range(0, hi);
    endtask
    task automatic check_zero();
        chk("rst_stage_val", int'(arr.stage_val), 0);
        chk("rst_s_rdy", int'(arr.nonlinear_s_rdy), 0);
        chk("rst_s_val", int'(arr.nonlinear_s_val), 0);
        chk("rst_nl_start", int'(nl_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cur_stage", int'(cur_stage), 0);
        chk("rst_l_k", int'(arr.l_k), 0);
        chk("rst_landmark_num", int'(arr.landmark_num), 0);
    endtask
    // partner: reacts to the visible phase after a per-phase delay taken from d[]
    initial begin
        int   age, ph_q;
        logic ret;
        age = 0;
        ph_q = 0;
        ret = 1'b0;
        arr.stage_rdy = 3'b000;
        arr.nonlinear_m_val = 3'b000;
        arr.nonlinear_m_rdy = 3'b000;
        arr.rsa_done = 1'b0;
        nl_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (arr.stage_val != 3'b000 || !busy) ret = 1'b0;
            if (arr.nonlinear_s_val != 3'b000) ret = 1'b1;
            ph = arr.stage_val != 3'b000 ? 1 : arr.nonlinear_s_rdy != 3'b000 ? 2 :
                 arr.nonlinear_s_val != 3'b000 ? 4 : !busy ? 0 : ret ? 5 : 3;
            age = ph == ph_q ? age + 1 : 0;
            ph_q = ph;
            arr.stage_rdy = (ph == 1 && !no_rdy && age >= d[0]) ? arr.stage_val : 3'b000;
            arr.nonlinear_m_val = (ph == 2 && age >= d[1]) ?
                ((wrong && age < d[1] + 2) ? {arr.nonlinear_s_rdy[0], arr.nonlinear_s_rdy[2:1]} : arr.nonlinear_s_rdy) : 3'b000;
            nl_done = ph == 3 && age == d[2];
            arr.nonlinear_m_rdy = (ph == 4 && age >= d[3]) ? arr.nonlinear_s_val : 3'b000;
            arr.rsa_done = ph == 5 && age == d[4];
        end
    end
    // monitor: pops one expectation per done or err pulse
    initial begin
        ev_t e;
        int  seen, nls, issue_run;
        seen = 0;
        nls = 0;
        issue_run = 0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                seen = 0;
                nls = 0;
                issue_run = 0;
            end else begin
                if (arr.stage_val != 3'b000) begin
                    seen = int'(arr.stage_val);
                    issue_run++;
                    chk("stage_val_vs_cur_stage", int'(arr.stage_val), int'(cur_stage));
                end
                if (nl_start) nls++;
                if (done || err != 2'b00) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got done=%0d err=%0d, required no event", done, err);
                    end else begin
                        e = q.pop_front();
                        chk("err_code", int'(err), int'(e.err));
                        chk("done_flag", int'(done), e.err == ERR_NONE ? 1 : 0);
                        chk("served_stage", seen, int'(e.stg));
                        chk("landmark_num", int'(arr.landmark_num), e.lm);
                        chk("nl_start_count", nls, e.err == ERR_NONE ? 1 : 0);
                        chk("busy_at_event", int'(busy), 0);
                        if (e.err == ERR_TO) chk("issue_cycles", issue_run, 15);
                        if (e.lk >= 0) chk("l_k", int'(arr.l_k), e.lk);
                    end
                    seen = 0;
                    nls = 0;
                    issue_run = 0;
                end
            end
        end
    end
    initial begin
        int       n;
        logic [2:0] b;
        int       lk;
        d = '{1, 1, 2, 0, 1};
        repeat (3) @(posedge clk);
        #1;
        check_zero();
        sys_rst = 1'b0;
        expect_batch(3'b010, 7);
        req(3'b010, 7);
        drain(200);
        d = '{0, 0, 8, 0, 0};
        req(3'b001, 0);
        n = 0;
        while (ph != 3 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_nl_calc", int'(ph == 3), 1);
        sys_rst = 1'b1;
        @(posedge clk); #1;
        check_zero();
        sys_rst = 1'b0;
        m_lm = 0;
        repeat (2) @(posedge clk);
        d = '{0, 2, 3, 0, 1};
        expect_batch(3'b001, 0);
        req(3'b001, 0);
        drain(200);
        wrong = 1'b1;
        d = '{0, 1, 2, 0, 0};
        expect_batch(3'b001, 0);
        req(3'b001, 0);
        drain(200);
        wrong = 1'b0;
        set_rand(3);
        expect_batch(3'b111, 33);
        req(3'b111, 33);
        drain(300);
        d = '{3, 1, 1, 1, 1};
        expect_batch(3'b001, 0);
        q.push_back('{ERR_NONE, 3'b100, m_lm, 21});
        req(3'b001, 0);
        req(3'b100, 12);
        req(3'b100, 21);
        drain(300);
        set_rand(2);
        expect_batch(3'b001, 0);
        req(3'b001, 0);
        n = 0;
        while (!arr.rsa_done && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_rsa_done", int'(arr.rsa_done), 1);
        req_val = 3'b010;
        req_lk = RL'(55);
        expect_batch(3'b010, 55);
        @(posedge clk); #1;
        req_val = 3'b000;
        drain(300);
        for (int i = 0; i < 20; i++) begin
            set_rand(5);
            b = 3'($urandom_range(1, 7));
            lk = $urandom_range(0, 1023);
            expect_batch(b, lk);
            req(b, lk);
            drain(400);
        end
        while (m_lm < MAXL) begin
            set_rand(1);
            lk = $urandom_range(0, 1023);
            expect_batch(3'b010, lk);
            req(3'b010, lk);
            drain(100);
        end
        expect_batch(3'b010, 9);
        req(3'b010, 9);
        drain(100);
        set_rand(2);
        expect_batch(3'b111, 77);
        req(3'b111, 77);
        drain(300);
        no_rdy = 1'b1;
        q.push_back('{ERR_TO, 3'b001, m_lm, -1});
        req(3'b001, 0);
        drain(100);
        no_rdy = 1'b0;
        chk("busy_after_timeout", int'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
